// File: rtl/sccb_slave.sv
// sccb_slave: SCCB responder (camera side of the OV7670 config link).
// Oversamples sclk/sdat_in on clk, decodes start/stop, matches DEV_ID,
// acknowledges bytes, emits register-write strobes and serves reads.
// Optional feature: define SCCB_SLAVE_AUTOINC_EN for multi-byte bursts
// with sub-address auto-increment on both writes and reads.
module sccb_slave #(
    parameter logic [6:0] DEV_ID      = 7'h21,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       sdat_in,
    output logic       sdat_on,
    output logic       sdat_out,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       id_err
);

`ifdef SCCB_SLAVE_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, ID, ACK_ID, ADDR, ACK_ADDR, DATA, ACK_DATA, RD_BIT, RD_NA, WAIT_STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdat_sync;
    logic                   sclk_prev;
    logic                   sdat_prev;
    logic                   s_sclk;
    logic                   s_sdat;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   start_det;
    logic                   stop_det;
    logic [2:0]             bit_cnt;
    logic [6:0]             shreg;
    logic [7:0]             byte_next;
    logic [6:0]             rd_shift;
    logic [7:0]             sub_addr;
    logic                   rw;
    logic                   nack;

    // Synchronizers and one-cycle-delayed copies for edge detection; idle bus is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '1;
            sdat_sync <= '1;
            sclk_prev <= 1'b1;
            sdat_prev <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], sdat_in};
            sclk_prev <= s_sclk;
            sdat_prev <= s_sdat;
        end
    end

    assign s_sclk    = sclk_sync[SYNC_STAGES-1];
    assign s_sdat    = sdat_sync[SYNC_STAGES-1];
    assign sclk_rise = s_sclk & ~sclk_prev;
    assign sclk_fall = ~s_sclk & sclk_prev;
    assign start_det = sclk_prev & s_sclk & sdat_prev & ~s_sdat;
    assign stop_det  = sclk_prev & s_sclk & ~sdat_prev & s_sdat;
    assign byte_next = {shreg, s_sdat};
    assign rd_addr   = sub_addr;
    assign busy      = (state != IDLE);

    // Protocol FSM: bits sampled on sclk rise, line drive changed only on sclk fall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sdat_on  <= 1'b0;
            sdat_out <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            id_err   <= 1'b0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rd_shift <= '0;
            sub_addr <= '0;
            rw       <= 1'b0;
            nack     <= 1'b1;
        end else begin
            wr_en  <= 1'b0;
            id_err <= 1'b0;
            if (start_det) begin
                state    <= ID;
                bit_cnt  <= '0;
                sdat_on  <= 1'b0;
                sdat_out <= 1'b0;
            end else if (stop_det) begin
                state    <= IDLE;
                sdat_on  <= 1'b0;
                sdat_out <= 1'b0;
            end else if (sclk_rise) begin
                case (state)
                    ID, ADDR, DATA: begin
                        shreg   <= byte_next[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            case (state)
                                ID: begin
                                    if (byte_next[7:1] != DEV_ID) begin
                                        id_err <= 1'b1;
                                        state  <= WAIT_STOP;
                                    end else begin
                                        rw    <= byte_next[0];
                                        state <= ACK_ID;
                                    end
                                end
                                ADDR: begin
                                    sub_addr <= byte_next;
                                    state    <= ACK_ADDR;
                                end
                                default: begin
                                    wr_addr <= sub_addr;
                                    wr_data <= byte_next;
                                    wr_en   <= 1'b1;
                                    if (AUTOINC) sub_addr <= sub_addr + 8'd1;
                                    state   <= ACK_DATA;
                                end
                            endcase
                        end
                    end
                    RD_NA:   nack <= s_sdat;
                    default: ;
                endcase
            end else if (sclk_fall) begin
                case (state)
                    ACK_ID, ACK_ADDR, ACK_DATA: begin
                        // first fall after bit 8 starts the ACK, the next one ends it
                        if (!sdat_on) begin
                            sdat_on  <= 1'b1;
                            sdat_out <= 1'b0;
                        end else begin
                            bit_cnt  <= '0;
                            sdat_on  <= 1'b0;
                            sdat_out <= 1'b0;
                            case (state)
                                ACK_ID: begin
                                    if (rw) begin
                                        sdat_on  <= 1'b1;
                                        sdat_out <= rd_data[7];
                                        rd_shift <= rd_data[6:0];
                                        bit_cnt  <= 3'd1;
                                        state    <= RD_BIT;
                                    end else begin
                                        state <= ADDR;
                                    end
                                end
                                ACK_ADDR: state <= DATA;
                                default:  state <= AUTOINC ? DATA : WAIT_STOP;
                            endcase
                        end
                    end
                    RD_BIT: begin
                        // bit_cnt wraps to 0 once all 8 bits have been put on the line
                        if (bit_cnt == 3'd0) begin
                            sdat_on  <= 1'b0;
                            sdat_out <= 1'b0;
                            nack     <= 1'b1;
                            if (AUTOINC) sub_addr <= sub_addr + 8'd1;
                            state    <= RD_NA;
                        end else begin
                            sdat_out <= rd_shift[6];
                            rd_shift <= {rd_shift[5:0], 1'b0};
                            bit_cnt  <= bit_cnt + 3'd1;
                        end
                    end
                    RD_NA: begin
                        if (AUTOINC && !nack) begin
                            sdat_on  <= 1'b1;
                            sdat_out <= rd_data[7];
                            rd_shift <= rd_data[6:0];
                            bit_cnt  <= 3'd1;
                            state    <= RD_BIT;
                        end else begin
                            state <= WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_slave.sv
// tb_sccb_slave: directed self-checking bench for sccb_slave.
// Models an SCCB master on a wired-AND data line and a register array.
`timescale 1ns/1ps
module tb_sccb_slave;

    localparam int Q = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sdat_line;
    logic       sdat_on, sdat_out, wr_en, busy, id_err;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [7:0] regs [256];

    int checks = 0;
    int errors = 0;

    int         wr_cnt = 0;
    int         id_cnt = 0;
    int         on_cnt = 0;
    logic [7:0] log_addr [64];
    logic [7:0] log_data [64];

    always #5 clk = ~clk;

    assign sdat_line = m_sda & ~(sdat_on & ~sdat_out);
    assign rd_data   = regs[rd_addr];

    sccb_slave #(.DEV_ID(7'h21), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(scl), .sdat_in(sdat_line),
        .sdat_on(sdat_on), .sdat_out(sdat_out), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .id_err(id_err)
    );

    // Event monitor sampled on the inactive clock edge
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                log_addr[wr_cnt % 64] <= wr_addr;
                log_data[wr_cnt % 64] <= wr_data;
                wr_cnt <= wr_cnt + 1;
            end
            if (id_err) id_cnt <= id_cnt + 1;
            if (sdat_on) on_cnt <= on_cnt + 1;
        end
    end

    task automatic bus_start();
        #Q m_sda = 1'b0;
        #Q scl = 1'b0;
    endtask

    task automatic bus_restart();
        #Q m_sda = 1'b1;
        #Q scl = 1'b1;
        #Q m_sda = 1'b0;
        #Q scl = 1'b0;
    endtask

    task automatic bus_stop();
        #Q m_sda = 1'b0;
        #Q scl = 1'b1;
        #Q m_sda = 1'b1;
        #Q;
    endtask

    task automatic bit_out(input logic b);
        #Q m_sda = b;
        #Q scl = 1'b1;
        #(2*Q) scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a_on, output logic a_val);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        #Q m_sda = 1'b1;
        #Q scl = 1'b1;
        #Q a_on = sdat_on; a_val = sdat_out;
        #Q scl = 1'b0;
    endtask

    task automatic read_byte(input logic nk, output logic [7:0] d, output int on_bits, output logic rel_on);
        d = '0;
        on_bits = 0;
        for (int i = 0; i < 8; i++) begin
            #Q m_sda = 1'b1;
            #Q scl = 1'b1;
            #Q d = {d[6:0], sdat_out};
            if (sdat_on) on_bits++;
            #Q scl = 1'b0;
        end
        #Q m_sda = nk;
        #Q scl = 1'b1;
        #Q rel_on = sdat_on;
        #Q scl = 1'b0;
    endtask

    task automatic test_reset();
        #23;
        checks++; if (sdat_on !== 1'b0) begin errors++; $display("FAIL reset_sdat_on got %b exp 0", sdat_on); end
        checks++; if (sdat_out !== 1'b0) begin errors++; $display("FAIL reset_sdat_out got %b exp 0", sdat_out); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
        checks++; if ({wr_addr, wr_data, rd_addr} !== 24'h0) begin errors++; $display("FAIL reset_addr_data got %h exp 000000", {wr_addr, wr_data, rd_addr}); end
        checks++; if ({busy, id_err} !== 2'b00) begin errors++; $display("FAIL reset_busy_iderr got %b exp 00", {busy, id_err}); end
        #2 rst = 1'b0;
        #40;
    endtask

    task automatic test_write3();
        logic a_on, a_val;
        int   w0;
        logic [7:0] bytes [3];
        bytes[0] = 8'h42; bytes[1] = 8'h12; bytes[2] = 8'h80;
        w0 = wr_cnt;
        bus_start();
        for (int i = 0; i < 3; i++) begin
            send_byte(bytes[i], a_on, a_val);
            checks++; if ({a_on, a_val} !== 2'b10) begin errors++; $display("FAIL write3_ack%0d got on=%b out=%b exp on=1 out=0", i, a_on, a_val); end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write3_busy_mid got %b exp 1", busy); end
        bus_stop();
        #40;
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL write3_count got %0d exp 1", wr_cnt - w0); end
        checks++; if ({log_addr[w0 % 64], log_data[w0 % 64]} !== 16'h1280) begin errors++; $display("FAIL write3_addr_data got %h exp 1280", {log_addr[w0 % 64], log_data[w0 % 64]}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write3_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_id_mismatch();
        logic a_on, a_val;
        int w0, i0, o0;
        w0 = wr_cnt; i0 = id_cnt; o0 = on_cnt;
        bus_start();
        send_byte(8'h60, a_on, a_val);
        send_byte(8'h12, a_on, a_val);
        bus_stop();
        #40;
        checks++; if (id_cnt - i0 !== 1) begin errors++; $display("FAIL idmis_pulses got %0d exp 1", id_cnt - i0); end
        checks++; if (on_cnt - o0 !== 0) begin errors++; $display("FAIL idmis_drive_cycles got %0d exp 0", on_cnt - o0); end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL idmis_writes got %0d exp 0", wr_cnt - w0); end
    endtask

    task automatic test_read();
        logic a_on, a_val, rel;
        logic [7:0] d;
        int nb, w0;
        w0 = wr_cnt;
        bus_start();
        send_byte(8'h42, a_on, a_val);
        send_byte(8'h0A, a_on, a_val);
        bus_stop();
        #40;
        checks++; if (rd_addr !== 8'h0A) begin errors++; $display("FAIL read_rd_addr got %h exp 0a", rd_addr); end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL read_2phase_writes got %0d exp 0", wr_cnt - w0); end
        bus_start();
        send_byte(8'h43, a_on, a_val);
        checks++; if ({a_on, a_val} !== 2'b10) begin errors++; $display("FAIL read_ack_id got on=%b out=%b exp on=1 out=0", a_on, a_val); end
        read_byte(1'b1, d, nb, rel);
        checks++; if (d !== 8'h76) begin errors++; $display("FAIL read_data got %h exp 76", d); end
        checks++; if (nb !== 8) begin errors++; $display("FAIL read_drive_bits got %0d exp 8", nb); end
        checks++; if (rel !== 1'b0) begin errors++; $display("FAIL read_release_9th got %b exp 0", rel); end
        bus_stop();
        #40;
    endtask

    task automatic test_partial_stop();
        logic a_on, a_val;
        int w0;
        w0 = wr_cnt;
        bus_start();
        send_byte(8'h42, a_on, a_val);
        send_byte(8'h20, a_on, a_val);
        for (int i = 0; i < 4; i++) bit_out(i[0]);
        bus_stop();
        #40;
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL partial_writes got %0d exp 0", wr_cnt - w0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid_ack();
        logic a_on, a_val;
        logic [7:0] ab;
        int w0;
        ab = 8'h07;
        bus_start();
        send_byte(8'h42, a_on, a_val);
        for (int i = 7; i >= 0; i--) bit_out(ab[i]);
        #Q;
        checks++; if (sdat_on !== 1'b1) begin errors++; $display("FAIL rstmid_ack_driving got %b exp 1", sdat_on); end
        #2 rst = 1'b1;
        #1;
        checks++; if (sdat_on !== 1'b0) begin errors++; $display("FAIL rstmid_async_release got %b exp 0", sdat_on); end
        #27 rst = 1'b0;
        m_sda = 1'b1;
        #Q scl = 1'b1;
        #Q;
        w0 = wr_cnt;
        bus_start();
        send_byte(8'h42, a_on, a_val);
        send_byte(8'h05, a_on, a_val);
        send_byte(8'h33, a_on, a_val);
        checks++; if ({a_on, a_val} !== 2'b10) begin errors++; $display("FAIL rstmid_data_ack got on=%b out=%b exp on=1 out=0", a_on, a_val); end
        bus_stop();
        #40;
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL rstmid_writes got %0d exp 1", wr_cnt - w0); end
        checks++; if ({log_addr[w0 % 64], log_data[w0 % 64]} !== 16'h0533) begin errors++; $display("FAIL rstmid_addr_data got %h exp 0533", {log_addr[w0 % 64], log_data[w0 % 64]}); end
    endtask

    task automatic test_burst();
        logic a1_on, a1_val, a2_on, a2_val, x_on, x_val;
        int w0;
        w0 = wr_cnt;
        bus_start();
        send_byte(8'h42, x_on, x_val);
        send_byte(8'hFF, x_on, x_val);
        send_byte(8'h01, a1_on, a1_val);
        send_byte(8'h02, a2_on, a2_val);
        bus_stop();
        #40;
        checks++; if ({a1_on, a1_val} !== 2'b10) begin errors++; $display("FAIL burst_ack1 got on=%b out=%b exp on=1 out=0", a1_on, a1_val); end
        checks++; if ({log_addr[w0 % 64], log_data[w0 % 64]} !== 16'hFF01) begin errors++; $display("FAIL burst_write1 got %h exp ff01", {log_addr[w0 % 64], log_data[w0 % 64]}); end
`ifdef SCCB_SLAVE_AUTOINC_EN
        checks++; if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL burst_writes got %0d exp 2", wr_cnt - w0); end
        checks++; if ({a2_on, a2_val} !== 2'b10) begin errors++; $display("FAIL burst_ack2 got on=%b out=%b exp on=1 out=0", a2_on, a2_val); end
        checks++; if ({log_addr[(w0 + 1) % 64], log_data[(w0 + 1) % 64]} !== 16'h0002) begin errors++; $display("FAIL burst_write2 got %h exp 0002", {log_addr[(w0 + 1) % 64], log_data[(w0 + 1) % 64]}); end
`else
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL burst_writes got %0d exp 1", wr_cnt - w0); end
        checks++; if (a2_on !== 1'b0) begin errors++; $display("FAIL burst_noack2 got on=%b exp 0", a2_on); end
`endif
    endtask

    task automatic test_back_to_back();
        logic a_on, a_val, rel;
        logic [7:0] d;
        int nb, w0;
        w0 = wr_cnt;
        bus_start();
        send_byte(8'h42, a_on, a_val);
        send_byte(8'h30, a_on, a_val);
        checks++; if ({a_on, a_val} !== 2'b10) begin errors++; $display("FAIL b2b_ack_addr got on=%b out=%b exp on=1 out=0", a_on, a_val); end
        bus_restart();
        send_byte(8'h43, a_on, a_val);
        checks++; if ({a_on, a_val} !== 2'b10) begin errors++; $display("FAIL b2b_ack_id got on=%b out=%b exp on=1 out=0", a_on, a_val); end
        read_byte(1'b1, d, nb, rel);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL b2b_read_data got %h exp a5", d); end
        bus_stop();
        #40;
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL b2b_writes got %0d exp 0", wr_cnt - w0); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        regs[8'h0A] = 8'h76;
        regs[8'h30] = 8'hA5;
        test_reset();
        test_write3();
        test_id_mismatch();
        test_read();
        test_partial_stop();
        test_reset_mid_ack();
        test_burst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_slave.md
# sccb_slave

Synthesizable SCCB responder: the camera-side end of the OV7670 configuration link driven by our SCCB master. It oversamples `sclk`/`sdat` on the FPGA clock, decodes start/stop conditions, matches the device ID and acknowledges bytes. It turns 3-phase writes into register-write strobes and answers 2-phase write + 2-phase read sequences from an external register array. It is used as an on-chip loopback target for the camera controller and as a camera stand-in in benches.

## Interface

Parameters:
- `DEV_ID`, default 7'h21: 7-bit SCCB device ID. Write byte is 0x42, read byte is 0x43.
- `SYNC_STAGES`, default 2: synchronizer depth on `sclk` and `sdat_in`; minimum 2.

Ports:
- `clk` in 1: FPGA clock; must run at ≥ 8× `sclk` frequency.
- `rst` in 1: reset; asynchronous, active-high.
- `sclk` in 1: SCCB clock from master.
- `sdat_in` in 1: SCCB data line as seen on the bus.
- `sdat_on` out 1: '1' = slave drives the data line.
- `sdat_out` out 1: value driven when `sdat_on`=1.
- `wr_en` out 1: one-cycle register-write strobe.
- `wr_addr` out 8: register sub-address for the write.
- `wr_data` out 8: register data for the write.
- `rd_addr` out 8: current sub-address, presented to the register array.
- `rd_data` in 8: register contents at `rd_addr`.
- `busy` out 1: transaction in progress, from start to stop.
- `id_err` out 1: one-cycle pulse on ID mismatch.

## Operation

- Inputs pass through `SYNC_STAGES` flops. Edges are detected on the synchronized signals.
  - Start: `sdat` falls while `sclk`=1.
  - Stop: `sdat` rises while `sclk`=1.
  - Data bits are sampled at `sclk` rising edges. The slave changes its drive only at `sclk` falling edges.
- States: IDLE, ID, ACK_ID, ADDR, ACK_ADDR, DATA, ACK_DATA, RD_BIT, RD_NA, WAIT_STOP.
- IDLE → ID on start. Shift 8 bits, MSB first.
- ID complete:
  - If `id[7:1]`≠`DEV_ID`: pulse `id_err` and go to WAIT_STOP, with no acknowledge.
  - If R/W=0: go to ACK_ID, then ADDR.
  - If R/W=1: go to ACK_ID, then RD_BIT.
- ADDR: the byte is latched into the sub-address register (`rd_addr`), then ACK_ADDR, then DATA.
  - A stop here ends a 2-phase write. The sub-address is retained for a following read.
- DATA: on the 8th bit, load `wr_addr`=sub-address and `wr_data`=byte, and pulse `wr_en`. Then ACK_DATA, then WAIT_STOP.
- Acknowledge (9th bit): from the `sclk` fall after bit 8 until the `sclk` fall after bit 9, drive `sdat_on`=1, `sdat_out`=0.
- RD_BIT:
  - `rd_data` is captured at the `sclk` fall ending ACK_ID.
  - Shift it out MSB first, changing at each `sclk` fall, with `sdat_on`=1.
  - After bit 8, release the line and go to RD_NA. The master's 9th bit is ignored.
  - Then WAIT_STOP.
- Start detected in any state: restart at ID (repeated start). The sub-address is kept.
- Stop detected in any state: go to IDLE and release the line. A partially received byte produces no `wr_en`.
- `busy`=1 in every state except IDLE.

## Timing

- Reset values: `sdat_on`=0, `sdat_out`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rd_addr`=0, `busy`=0, `id_err`=0. State is IDLE; the sub-address is 0.
- Reset acts immediately, including mid-transaction: `sdat_on` drops without waiting for a clock edge.
- Edge-detect latency: `SYNC_STAGES`+1 `clk` cycles after the bus pin changes.
- `wr_en` is high exactly one cycle, in the cycle after the 8th data-bit rising edge is detected. `wr_addr`/`wr_data` are valid in that cycle and hold until the next write.
- `rd_data` must be stable for at least 1 `clk` after `rd_addr` changes. `rd_addr` changes only on ADDR completion (or auto-increment, see Configuration).
- Drive changes lag the detected `sclk` fall by 1 `clk`. This leaves at least 3 `clk` of setup before the next `sclk` rise when `clk` ≥ 8× `sclk`.

## Configuration

- `SCCB_SLAVE_AUTOINC_EN` defined:
  - After ACK_DATA, return to DATA instead of WAIT_STOP.
  - Each further byte increments the sub-address by 1 (8-bit wrap, 0xFF→0x00), is written with its own `wr_en`, and is acknowledged.
  - In reads, the sub-address also increments after each byte, and the slave continues sending if the master's 9th bit is 0.
- Undefined:
  - Exactly one data byte per write; further bytes are not acknowledged and produce no `wr_en`.
  - A read returns exactly one byte.

## Test plan

- 3-phase write 0x42, 0x12, 0x80, then stop → exactly one `wr_en` with `wr_addr`=0x12, `wr_data`=0x80. `sdat_on`=1/`sdat_out`=0 on all three 9th bits. `busy` returns to 0 after the stop.
- Write byte 0x60, then 0x12 → one `id_err` pulse, `sdat_on` never asserted, no `wr_en`.
- 2-phase write 0x42, 0x0A, stop; then 0x43 with `rd_data`=0x76 → `rd_addr`=0x0A, `sdat_out` sequence 0,1,1,1,0,1,1,0 during RD_BIT, line released on the 9th bit.
- Stop after 4 DATA bits of write 0x42, 0x20 → no `wr_en`, state IDLE, `busy`=0.
- `rst` asserted mid-ACK_ADDR → `sdat_on`=0 within the same cycle. After release, a full write 0x42, 0x05, 0x33 succeeds.
- Write 0x42, 0xFF, 0x01, 0x02 → with `SCCB_SLAVE_AUTOINC_EN`: writes (0xFF,0x01) and (0x00,0x02), both acknowledged. Without it: a single write (0xFF,0x01), and the second byte is not acknowledged.
